// File: rtl/transpad_cmd_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | transpad_cmd_queue_if : host command handshake and array issue bus       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface transpad_cmd_queue_if;
  logic        flush;
  logic        stall;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_unit;
  logic [2:0]  in_cmd;
  logic [47:0] in_data;
  logic [2:0]  unit;
  logic        rdy;
  logic [2:0]  cmd;
  logic [47:0] data;
  logic [4:0]  count;

  modport master (
    output flush, stall, in_valid, in_unit, in_cmd, in_data,
    input  in_ready, unit, rdy, cmd, data, count
  );

  modport slave (
    input  flush, stall, in_valid, in_unit, in_cmd, in_data,
    output in_ready, unit, rdy, cmd, data, count
  );
endinterface
`default_nettype wire

// File: rtl/transpad_cmd_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | transpad_cmd_queue : FIFO command buffer, one issue per cycle to array   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module transpad_cmd_queue #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  transpad_cmd_queue_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = 54;
  localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
  localparam logic [4:0] c_depth = 5'(DEPTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [4:0]         r_count;
  logic               r_rdy;
  logic [2:0]         r_unit;
  logic [2:0]         r_cmd;
  logic [47:0]        r_data;

  logic               w_in_ready;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head_entry;

  // Ready depends only on registered occupancy, so a full queue stays
  // not-ready even on a cycle that also pops.
  assign w_in_ready   = (r_count < c_depth);
  assign w_push       = bus.in_valid & w_in_ready & ~bus.flush;
  assign w_pop        = (r_count != 5'd0) & ~bus.stall & ~bus.flush;
  assign w_head_entry = r_mem[r_head];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= {bus.in_unit, bus.in_cmd, bus.in_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 5'd0;
      r_rdy   <= 1'b0;
      r_unit  <= 3'd0;
      r_cmd   <= 3'd0;
      r_data  <= 48'd0;
    end else if (bus.flush) begin
      // Issued fields keep their last values; only the queue and strobe clear.
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 5'd0;
      r_rdy   <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + c_ptr_one;
      end
      if (w_pop) begin
        r_head <= r_head + c_ptr_one;
        r_rdy  <= 1'b1;
        r_unit <= w_head_entry[53:51];
        r_cmd  <= w_head_entry[50:48];
        r_data <= w_head_entry[47:0];
      end else begin
        r_rdy  <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.rdy      = r_rdy;
  assign bus.unit     = r_unit;
  assign bus.cmd      = r_cmd;
  assign bus.data     = r_data;
  assign bus.count    = r_count;

endmodule
`default_nettype wire
